mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-ported `memory_block` between the instruction-fetch port and the load/store data port of the MIPS core. It accepts one request at a time from each port, grants round-robin on ties, drives the memory strobes for a fixed number of wait cycles, and returns registered read data with a one-cycle acknowledge. It sits between the core's fetch/LSU logic and `memory_block`, replacing the direct wiring of `memRead`, `memWrite`, `byteOperations` and `address`.

## Interface
- `ADDR_W`, 18: memory address width.
- `DATA_W`, 32: data width.
- `WAIT_CYCLES`, 1: cycles the strobes are held per access; legal range 1–15.

- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held until `if_ack`.
- `if_addr`  in  ADDR_W  fetch address.
- `if_ack`  out  1  one-cycle completion pulse.
- `if_rdata`  out  DATA_W  registered fetch data.
- `d_req`  in  1  data request; held until `d_ack`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_byte`  in  1  byte operation (lb/sb).
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_ack`  out  1  one-cycle completion pulse.
- `d_rdata`  out  DATA_W  registered load data.
- `mem_address`  out  ADDR_W  to `memory_block.address`.
- `mem_write_data`  out  DATA_W  to `memory_block.write_data`.
- `mem_memRead`, `mem_memWrite`, `mem_byteOperations`  out  1 each  memory strobes.
- `mem_read_data`  in  DATA_W  from `memory_block.read_data`.
- `busy`  out  1  high in every state other than IDLE.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - Samples `if_req`/`d_req` at each edge.
  - If only one is high, that port is granted.
  - If both are high, the port not granted last time is granted.
  - The `last_grant` register resets to IF, so the first tie after reset goes to data.
  - At the grant edge:
    - address, write data, `we` and `byte` are latched into internal registers (IF: we=0, byte=0);
    - `last_grant` is updated;
    - the wait counter is loaded with `WAIT_CYCLES-1`;
    - the state moves to ACCESS.
- **ACCESS**
  - Drives `mem_memRead = ~we`, `mem_memWrite = we`, `mem_byteOperations = byte` and `mem_address`/`mem_write_data` from the latched registers.
  - The counter decrements each edge.
  - At the edge where the counter is 0:
    - `mem_read_data` is captured into the granted port's rdata register (reads only);
    - the state moves to DONE.
- **DONE**
  - The granted port's ack is high for exactly this cycle.
  - Strobes are low.
  - The next state is IDLE unconditionally.
- **Request handling**
  - Requests are ignored outside IDLE.
  - A requester may drop `req` at the edge where it sees ack. No duplicate grant occurs, because DONE→IDLE consumes that edge.
  - If `req` drops before ack, the latched transaction still completes and ack still pulses.
- **Read data hold**
  - `if_rdata` changes only on completed fetches.
  - `d_rdata` changes only on completed loads. Stores leave `d_rdata` unchanged.
- **Signal holding**
  - `mem_address` and `mem_write_data` hold their last latched values in IDLE and DONE.
  - Strobes are 0 outside ACCESS.

## Timing
- **Reset:** all outputs 0, state IDLE, counter 0, `last_grant` = IF.
- **Reset mid-operation:** the access is aborted immediately (strobes fall asynchronously), no ack is issued, and the request is not replayed.
- **Latency:** grant at edge E; strobes are active in cycles E .. E+WAIT_CYCLES; ack is high in the cycle after edge E+WAIT_CYCLES.
- **Throughput:** one transaction per `WAIT_CYCLES+2` cycles with continuous requests. With `WAIT_CYCLES`=1 this is 3 cycles.
- **Fairness:** both ports continuously requesting alternate D, IF, D, IF, …; neither port waits more than one transaction.
- Requests asserted during ACCESS/DONE are first considered at the first IDLE edge.
- `busy` = (state != IDLE), registered with the state.

## Test plan
- **Reset:** assert `reset_n`=0 during ACCESS of a store → `mem_memWrite` falls to 0 without a clock edge; no `d_ack`; after release all outputs are 0 and the state is IDLE.
- **Single fetch** (`WAIT_CYCLES`=1, mem returns 0x8C010004 at addr 4): `if_req`=1, `if_addr`=4 → `mem_memRead`=1 for one cycle; `if_ack` is a one-cycle pulse 2 cycles after grant; `if_rdata`=0x8C010004; `d_rdata` is unchanged.
- **Byte store:** `d_req`=1, `d_we`=1, `d_byte`=1, `d_addr`=60, `d_wdata`=0xFF → `mem_memWrite`=1, `mem_byteOperations`=1, `mem_address`=60, `mem_memRead`=0; `d_ack` pulses; `d_rdata` is unchanged.
- **Tie after reset:** both requests rise together and are held → grant order D, IF, D, IF; acks spaced 3 cycles apart; no port is served twice in a row.
- **Early drop:** `if_req` drops during ACCESS → `if_ack` still pulses once and no second fetch is issued.
- **Long wait:** `WAIT_CYCLES`=4, load → strobes high for exactly 4 cycles; `d_ack` appears 5 cycles after grant; `d_rdata` equals the `mem_read_data` sampled on the 4th ACCESS edge.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Purpose : shares a single-ported memory between the fetch port and the load/store port; round-robin on ties.
// Latency : grant at edge E, strobes held for WAIT_CYCLES cycles, ack pulses in the cycle after edge E+WAIT_CYCLES.
// Backpress: one transaction in flight; requests are held by the requester and only sampled while IDLE.
//
// Ports: clock/reset_n; fetch port (if_req/if_addr -> if_ack/if_rdata);
//        data port (d_req/d_we/d_byte/d_addr/d_wdata -> d_ack/d_rdata);
//        memory side (mem_address/mem_write_data/strobes -> mem_read_data); busy.
module mem_port_arbiter #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_byte,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_memRead,
    output logic              mem_memWrite,
    output logic              mem_byteOperations,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t            state, state_nxt;
    logic [3:0]        cnt_q;
    logic              last_d_q;   // 1: data port won the previous grant
    logic              gnt_d_q;    // 1: transaction in flight belongs to data port
    logic              we_q;
    logic              byte_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic any_req;
    logic pick_d;
    logic finish;

    // On a tie the port that did not win last time gets the memory.
    assign any_req = if_req | d_req;
    assign pick_d  = d_req & (~if_req | ~last_d_q);
    assign finish  = (state == ACCESS) && (cnt_q == 4'd0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes and acks decode straight from the state register so that an
    // asynchronous reset drops them without waiting for a clock edge.
    always_comb begin
        state_nxt          = state;
        mem_memRead        = 1'b0;
        mem_memWrite       = 1'b0;
        mem_byteOperations = 1'b0;
        if_ack             = 1'b0;
        d_ack              = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_memRead        = ~we_q;
                mem_memWrite       = we_q;
                mem_byteOperations = byte_q;
                if (cnt_q == 4'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if_ack    = ~gnt_d_q;
                d_ack     = gnt_d_q;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= 4'd0;
            last_d_q   <= 1'b0;
            gnt_d_q    <= 1'b0;
            we_q       <= 1'b0;
            byte_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                cnt_q    <= CNT_LOAD;
                last_d_q <= pick_d;
                gnt_d_q  <= pick_d;
                if (pick_d) begin
                    we_q    <= d_we;
                    byte_q  <= d_byte;
                    addr_q  <= d_addr;
                    wdata_q <= d_wdata;
                end else begin
                    // Fetches are always full-word reads; keep the old write
                    // data so the memory-side bus does not toggle needlessly.
                    we_q   <= 1'b0;
                    byte_q <= 1'b0;
                    addr_q <= if_addr;
                end
            end else if (state == ACCESS && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            // Only reads update the return registers; stores leave d_rdata alone.
            if (finish && !we_q) begin
                if (gnt_d_q) begin
                    d_rdata_q <= mem_read_data;
                end else begin
                    if_rdata_q <= mem_read_data;
                end
            end
        end
    end

    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
    assign if_rdata       = if_rdata_q;
    assign d_rdata        = d_rdata_q;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 32;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    // Instance A: WAIT_CYCLES = 1
    logic              if_req, if_ack, d_req, d_we, d_byte, d_ack;
    logic [ADDR_W-1:0] if_addr, d_addr, mem_address;
    logic [DATA_W-1:0] if_rdata, d_wdata, d_rdata, mem_write_data, mem_read_data;
    logic              mem_memRead, mem_memWrite, mem_byteOperations, busy;

    // Instance B: WAIT_CYCLES = 4
    logic              l_if_req, l_if_ack, l_d_req, l_d_we, l_d_byte, l_d_ack;
    logic [ADDR_W-1:0] l_if_addr, l_d_addr, l_mem_address;
    logic [DATA_W-1:0] l_if_rdata, l_d_wdata, l_d_rdata, l_mem_write_data, l_mem_read_data;
    logic              l_mem_memRead, l_mem_memWrite, l_mem_byteOperations, l_busy;

    // Memory model for instance A: word at address 4 is a known instruction,
    // every other address returns a tagged copy of its address.
    assign mem_read_data = (mem_address == 18'd4) ? 32'h8C01_0004
                                                  : (32'hD000_0000 | {14'd0, mem_address});

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(1)) dut (
        .clock(clock), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
        .mem_byteOperations(mem_byteOperations), .mem_read_data(mem_read_data),
        .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(4)) dut_long (
        .clock(clock), .reset_n(reset_n),
        .if_req(l_if_req), .if_addr(l_if_addr), .if_ack(l_if_ack), .if_rdata(l_if_rdata),
        .d_req(l_d_req), .d_we(l_d_we), .d_byte(l_d_byte), .d_addr(l_d_addr), .d_wdata(l_d_wdata),
        .d_ack(l_d_ack), .d_rdata(l_d_rdata),
        .mem_address(l_mem_address), .mem_write_data(l_mem_write_data),
        .mem_memRead(l_mem_memRead), .mem_memWrite(l_mem_memWrite),
        .mem_byteOperations(l_mem_byteOperations), .mem_read_data(l_mem_read_data),
        .busy(l_busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] exp_ack;

        reset_n = 1'b0;
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_byte = 0; d_addr = '0; d_wdata = '0;
        l_if_req = 0; l_if_addr = '0; l_d_req = 0; l_d_we = 0; l_d_byte = 0;
        l_d_addr = '0; l_d_wdata = '0; l_mem_read_data = '0;
        repeat (3) @(negedge clock);

        // ---------------- reset state ----------------
        check("rst_busy", busy, 0);
        check("rst_strobes", {mem_memRead, mem_memWrite, mem_byteOperations}, 0);
        check("rst_acks", {if_ack, d_ack}, 0);
        check("rst_addr", mem_address, 0);
        check("rst_rdata", {if_rdata, d_rdata}, 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_busy", busy, 0);

        // ---------------- single fetch ----------------
        if_req = 1; if_addr = 18'd4;
        @(negedge clock);
        check("f_access_rd", {mem_memRead, mem_memWrite}, 2'b10);
        check("f_access_addr", mem_address, 4);
        check("f_access_busy", busy, 1);
        check("f_access_ack", if_ack, 0);
        @(negedge clock);
        check("f_done_ack", {if_ack, d_ack}, 2'b10);
        check("f_done_strobe", mem_memRead, 0);
        check("f_rdata", if_rdata, 32'h8C01_0004);
        check("f_d_rdata_kept", d_rdata, 0);
        if_req = 0;
        @(negedge clock);
        check("f_ack_gone", if_ack, 0);
        check("f_idle", busy, 0);

        // ---------------- byte store ----------------
        d_req = 1; d_we = 1; d_byte = 1; d_addr = 18'd60; d_wdata = 32'hFF;
        @(negedge clock);
        check("st_strobes", {mem_memRead, mem_memWrite, mem_byteOperations}, 3'b011);
        check("st_addr", mem_address, 60);
        check("st_wdata", mem_write_data, 32'hFF);
        @(negedge clock);
        check("st_ack", {if_ack, d_ack}, 2'b01);
        check("st_strobes_off", {mem_memRead, mem_memWrite, mem_byteOperations}, 0);
        check("st_d_rdata_kept", d_rdata, 0);
        d_req = 0; d_we = 0; d_byte = 0;
        @(negedge clock);
        check("st_ack_gone", d_ack, 0);
        check("st_addr_held", mem_address, 60);

        // ---------------- early drop ----------------
        if_req = 1; if_addr = 18'd8;
        @(negedge clock);
        check("ed_access", mem_memRead, 1);
        if_req = 0;
        @(negedge clock);
        check("ed_ack", if_ack, 1);
        check("ed_rdata", if_rdata, 32'hD000_0008);
        @(negedge clock);
        check("ed_ack_once", if_ack, 0);
        @(negedge clock);
        check("ed_no_refetch", {busy, mem_memRead}, 0);

        // ---------------- reset mid-store ----------------
        d_req = 1; d_we = 1; d_addr = 18'd12; d_wdata = 32'h55;
        @(negedge clock);
        check("rm_write_on", mem_memWrite, 1);
        #2 reset_n = 1'b0;
        #1;
        check("rm_write_async_off", mem_memWrite, 0);
        check("rm_busy_off", busy, 0);
        d_req = 0; d_we = 0;
        @(negedge clock);
        check("rm_no_ack1", d_ack, 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("rm_no_ack2", {if_ack, d_ack}, 0);
        check("rm_outputs", {mem_address, mem_write_data}, 0);
        check("rm_rdata", {if_rdata, d_rdata}, 0);
        check("rm_idle", busy, 0);

        // ---------------- tie after reset: D, IF, D, IF ----------------
        if_req = 1; if_addr = 18'd16;
        d_req = 1; d_we = 0; d_addr = 18'd20;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            case (k)
                2, 8:    exp_ack = 2'b01;
                5, 11:   exp_ack = 2'b10;
                default: exp_ack = 2'b00;
            endcase
            check($sformatf("tie_ack_c%0d", k), {if_ack, d_ack}, exp_ack);
            if (k == 1) check("tie_first_addr", mem_address, 20);
            if (k == 2) check("tie_d_rdata", d_rdata, 32'hD000_0014);
            if (k == 4) check("tie_second_addr", mem_address, 16);
            if (k == 5) check("tie_if_rdata", if_rdata, 32'hD000_0010);
        end
        if_req = 0; d_req = 0;
        @(negedge clock);
        check("tie_quiet", busy, 0);

        // ---------------- long wait (WAIT_CYCLES = 4) load ----------------
        l_d_req = 1; l_d_we = 0; l_d_addr = 18'd100;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (k <= 4) begin
                check($sformatf("lw_read_c%0d", k), l_mem_memRead, 1);
                check($sformatf("lw_ack_c%0d", k), l_d_ack, 0);
            end
            if (k == 1) check("lw_addr", l_mem_address, 100);
            if (k == 5) begin
                check("lw_read_off", l_mem_memRead, 0);
                check("lw_ack", l_d_ack, 1);
                check("lw_rdata", l_d_rdata, 32'hCAFE_0004);
                l_d_req = 0;
            end
            if (k == 6) check("lw_ack_gone", {l_d_ack, l_busy}, 0);
            // Value presented to the edge that follows this negedge.
            l_mem_read_data = 32'hCAFE_0000 + 32'(k);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
